// File: rtl/forward_scoreboard.sv
// forward_scoreboard: forwarding-select and load-use stall unit.
// Keeps its own shadow copy of the in-flight instructions (stage 0 = EXE
// consumer, stages 1..DEPTH = producers), so the datapath only supplies
// the ID-stage instruction fields.
module forward_scoreboard #(
  parameter int AW       = 5,
  parameter int NSRC     = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 2,
  parameter int SELW     = 2,
  parameter int CNTW     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_wen,
  input  logic                 id_load,
  input  logic [NSRC*AW-1:0]   id_src,
  input  logic                 flush,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic                 ex_valid,
  output logic                 id_stall,
  output logic [CNTW-1:0]      stall_count
);

  // Shadow pipeline: index 0 is the EXE consumer, 1..DEPTH the producers.
  logic [DEPTH:0]  valid_q, valid_d;
  logic [AW-1:0]   rd_q   [0:DEPTH];
  logic            wen_q  [0:DEPTH];
  logic            load_q [0:DEPTH];
  logic [AW-1:0]   src_q  [NSRC];

  logic [CNTW-1:0] stall_count_q, stall_count_d;
  logic            stall;

  // Load-use hazard: a load too young to forward still sits in stage 0..LOAD_LAT-2.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    stall = 1'b0;
    if (id_valid && !flush) begin
      for (int j = 0; j < LOAD_LAT - 1; j++) begin
        for (int s = 0; s < NSRC; s++) begin
          if (valid_q[j] && wen_q[j] && load_q[j] && (rd_q[j] != '0) &&
              (rd_q[j] == id_src[s*AW +: AW])) begin
            stall = 1'b1;
          end
        end
      end
    end
  end

  // Forward select: scan oldest to youngest so the youngest producer wins.
  always_comb begin
    fwd_sel = '0;
    if (valid_q[0]) begin
      for (int s = 0; s < NSRC; s++) begin
        for (int k = DEPTH; k >= 1; k--) begin
          if (valid_q[k] && wen_q[k] && (rd_q[k] != '0) && (rd_q[k] == src_q[s])) begin
            fwd_sel[s*SELW +: SELW] = SELW'(k);
          end
        end
      end
    end
  end

  // Next valid bits and saturating stall counter.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = (flush || stall) ? 1'b0 : id_valid;
    for (int k = 1; k <= DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
    end
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNTW'(1);
    end
  end

  // Control state: valid bits and counter, cleared by async reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is written with non-blocking assignments only, so all flops update together.
    if (rst) begin
      valid_q       <= '0;
      stall_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Payload shift: fields are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    // NOTE: payload arrays are deliberately unreset; only the valid bits carry reset meaning.
    rd_q[0]   <= id_rd;
    wen_q[0]  <= id_wen;
    load_q[0] <= id_load;
    for (int s = 0; s < NSRC; s++) begin
      src_q[s] <= id_src[s*AW +: AW];
    end
    for (int k = 1; k <= DEPTH; k++) begin
      rd_q[k]   <= rd_q[k-1];
      wen_q[k]  <= wen_q[k-1];
      load_q[k] <= load_q[k-1];
    end
  end

  assign ex_valid    = valid_q[0];
  assign id_stall    = stall;
  assign stall_count = stall_count_q;

endmodule

// File: doc/forward_scoreboard.md
Name: forward_scoreboard

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined datapath.
- Tracks in-flight destination registers internally in a DEPTH-stage shadow pipeline, so the datapath does not pass per-stage rd/wen.
- Each cycle it generates one forward-select code per EXE source operand, and raises an ID stall for load-use hazards with configurable load latency.
- Keeps a saturating count of stall cycles for performance analysis.

Parameters:
- AW, 5, register-address width.
- NSRC, 2, number of source operands per instruction.
- DEPTH, 2, number of producer stages after EXE that can forward (1 = EXE/MEM, 2 = MEM/WB, ...).
- LOAD_LAT, 2, first producer stage index at which load data is forwardable; legal range 1..DEPTH; 1 means no load-use stall.
- SELW, 2, select width; must satisfy 2^SELW > DEPTH.
- CNTW, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID-stage instruction present.
- id_rd  in  AW  ID-stage destination register.
- id_wen  in  1  ID-stage instruction writes the register file.
- id_load  in  1  ID-stage instruction is a load.
- id_src  in  NSRC*AW  ID-stage source registers; operand s occupies bits [s*AW +: AW].
- flush  in  1  kill the instruction entering EXE this cycle.
- fwd_sel  out  NSRC*SELW  per-operand select for the EXE instruction; operand s occupies bits [s*SELW +: SELW].
- ex_valid  out  1  stage-0 (EXE) entry is valid.
- id_stall  out  1  hold IF/ID this cycle.
- stall_count  out  CNTW  saturating count of stall cycles.

Behaviour:
- State consists of stage 0 (ID/EXE, the consumer) and stages 1..DEPTH (producers).
- Stage 0 holds {valid, rd, wen, load, src[NSRC]}. Stages 1..DEPTH hold {valid, rd, wen, load}.
- Reset (async): every valid bit clears, stall_count = 0. As a result fwd_sel = 0, ex_valid = 0 and id_stall = 0 while rst is high and after release.
- Every clock edge: stage k <= stage k-1 for k = 1..DEPTH. Stage DEPTH's old content is discarded.
- Stage 0 load rule, in priority order:
  - flush = 1: stage 0 <= bubble (valid = 0). The ID inputs are ignored.
  - id_stall = 1: stage 0 <= bubble.
  - otherwise: stage 0 <= ID inputs, with valid = id_valid.
- id_stall is combinational. It is 1 when all of the following hold:
  - id_valid = 1 and flush = 0.
  - For some operand s and some stage j with 0 <= j <= LOAD_LAT-2, stage j is valid, wen = 1, load = 1, rd != 0 and rd == id_src[s].
- LOAD_LAT = 1 gives id_stall = 0 always.
- While id_stall is asserted, upstream holds the ID inputs stable. The block re-evaluates them every cycle.
- fwd_sel[s] is combinational from registered state:
  - Value is 0 when stage 0 is invalid.
  - Otherwise it is the smallest k in 1..DEPTH where stage k is valid, wen = 1, rd != 0 and rd == stage0.src[s].
  - Value is 0 when no stage matches (use the register file).
  - The youngest producer always wins.
- Register 0 never matches, for either forwarding or stall.
- A load sitting in stage k < LOAD_LAT while a dependent consumer is in EXE cannot occur when the stall logic is correct. The bench asserts this never happens. If it does happen, the RTL still outputs k.
- stall_count increments by 1 on each edge where id_stall = 1, and saturates at 2^CNTW-1.
- Multiple operands naming the same register each receive the same select.
- A non-writing instruction (wen = 0) never forwards and never stalls, even when it is a load.

Test Plan:
- Back-to-back ALU dependency (default parameters): issue "r3 <- ...", then "src0 = r3, src1 = r3" -> with the consumer in EXE, fwd_sel = {2'd1, 2'd1}; id_stall = 0.
- Priority: r5 written by instructions two and one ahead, consumer src1 = r5 -> fwd_sel[1] = 1 (stage 1 wins over stage 2); src0 = r7 with no producer -> fwd_sel[0] = 0.
- Load-use: load r4, next instruction src0 = r4 -> id_stall = 1 for exactly one cycle and a bubble enters EXE (ex_valid = 0). The next cycle the consumer enters EXE with fwd_sel[0] = 2. stall_count = 1.
- LOAD_LAT = 3, DEPTH = 3: load r4 followed immediately by a consumer of r4 -> two stall cycles, then fwd_sel[0] = 3. stall_count = 2.
- r0 and wen = 0: producer rd = 0 with wen = 1, plus a load r6 with wen = 0; consumers reading r0 and r6 -> fwd_sel = 0 and id_stall = 0.
- Flush and reset: flush asserted during a load-use stall -> id_stall = 0 and a bubble enters EXE. Assert rst mid-stream with CNTW = 2 after 5 stalls: stall_count reads 3 (saturated) before reset, then 0 immediately on rst; fwd_sel = 0 and ex_valid = 0.
